sprite_layer_renderer: RTL and testbench
========================================

# sprite_layer_renderer

- Renders every tank and bullet sprite for the current pixel: up to `NUM_TANKS` tanks plus one bullet per tank.
- Pixel path is a 2-stage pipeline; output is RGB plus an opacity flag for compositing over the map layer.
- Sits between the game-state logic (positions, directions, show flags) and the VGA colour mux.
- Also detects bullet-on-tank pixel overlap and reports per-frame hit vectors back to game logic.

## Interface
- `NUM_TANKS`, default 4: tank channels and bullet channels; range 1..8.
- `TANK_SIZE`, default 32: tank sprite edge in pixels; power of two.
- `BULLET_SIZE`, default 8: bullet sprite edge in pixels; power of two.
- `KEY_RGB`, default 12'h000: ROM colour treated as transparent.

Ports (channel i of each packed vector occupies bits `[W*i+W-1 : W*i]`):
- `vga_clk` in 1: pixel clock; the only clock.
- `reset` in 1: asynchronous, active-high reset.
- `DrawX`, `DrawY` in 10 each: current pixel coordinate.
- `tank_x`, `tank_y` in 10·NUM_TANKS each: tank top-left corner.
- `tank_dir` in 4·NUM_TANKS: direction, one-hot. Bit 0 = up, 1 = down, 2 = left, 3 = right.
- `tank_show` in NUM_TANKS: tank enabled.
- `tank_enemy` in NUM_TANKS: selects the enemy palette.
- `bullet_x`, `bullet_y` in 10·NUM_TANKS each: bullet top-left corner.
- `bullet_dir` in 4·NUM_TANKS: same encoding as `tank_dir`.
- `bullet_show` in NUM_TANKS: bullet in flight.
- `red`, `green`, `blue` out 4 each: sprite colour, registered.
- `pixel_opaque` out 1: a sprite owns this pixel.
- `tank_hit` out NUM_TANKS: tank j was hit last frame.
- `bullet_hit` out NUM_TANKS: bullet i hit a tank last frame.
- `hits_valid` out 1: one-cycle pulse when the hit vectors update.

## Operation
**Stage 0 (registered at the first `vga_clk` edge)**
- Covers test: a channel covers the pixel when `x <= DrawX < x + SIZE` and `y <= DrawY < y + SIZE`, with its show flag set.
  - Sums are 11-bit, so a sprite at x ≥ 1024−SIZE does not wrap.
- Winner selection: the lowest-index covering tank is the tank winner; the lowest-index covering bullet is the bullet winner.
- ROM address = `(DrawY−y)·SIZE + (DrawX−x)`.
- Also registered: winner indices, their valid bits, direction, enemy bit, and a `frame_start` marker (`DrawX==0 && DrawY==0`).

**ROM read**
- Only one tank ROM set and one bullet ROM set exist (up/down/left/right each), addressed by the winners.
- The ROMs are clocked on `vga_clk`, with 1-cycle read latency.

**Stage 1 (output register)**
- Direction decode: lowest set bit wins; `dir == 0` gives 0xFFF fill.
- A channel pixel is opaque when its winner is valid and its ROM colour ≠ `KEY_RGB`.
- Priority: opaque bullet, then opaque tank, then nothing (RGB 0, `pixel_opaque = 0`).
- A transparent bullet pixel falls through to the tank underneath.

**Collision (with the macro enabled)**
- A hit is an opaque bullet pixel from bullet i coinciding with an opaque tank pixel from tank j, where i ≠ j.
- On a hit, OR-accumulate `bullet_hit_acc[i]` and `tank_hit_acc[j]`.
- Own-bullet overlap is ignored.
- Only the winning tank is tested; an occluded lower-priority tank is not.
- Frame boundary: when `frame_start` reaches stage 1:
  - copy the accumulators to `tank_hit`/`bullet_hit`;
  - pulse `hits_valid`;
  - clear the accumulators;
  - the pixel carrying `frame_start` accumulates into the cleared (new) frame.
  - Pixels still in flight from the prior frame are counted in the prior frame.

## Timing
- Latency: 2 `vga_clk` cycles from `DrawX`/`DrawY` to `red`/`green`/`blue`/`pixel_opaque`. The VGA timing must delay sync by 2 cycles to match.
- Throughput: one pixel per cycle, no stalls.
- The position, direction and show inputs are sampled with `DrawX`/`DrawY` in stage 0. They may change mid-frame; each pixel uses the values sampled with it.
- `hits_valid` asserts 2 cycles after `DrawX == 0 && DrawY == 0` is presented.
- Reset values:
  - all outputs 0;
  - pipeline valid bits 0;
  - accumulators 0.
- Reset mid-frame discards the partial frame's hits. The first `hits_valid` after reset reports the partial frame that follows reset.

## Configuration
- `SPRITE_COLLISION_EN` defined: the accumulators, hit outputs and `hits_valid` are generated as described above.
- `SPRITE_COLLISION_EN` undefined: collision logic is not compiled; `tank_hit`, `bullet_hit` and `hits_valid` are tied to 0. The pixel path is unchanged.

## Test plan
- **Single tank.** Tank 0 at (100,100), dir = up, show. Scan (100..131, 100..131).
  - Expect up-ROM pixels with 2-cycle latency.
  - Expect `pixel_opaque = 0` at x = 132.
- **Priority.** Tanks 1 and 2 both at (200,50).
  - Expect only tank 1's colours.
  - Hide tank 1: expect tank 2's colours.
- **Transparency.** Bullet 0 at (104,104) over tank 1 at (100,100).
  - Opaque bullet pixels show bullet colour.
  - `KEY_RGB` bullet pixels show tank colour.
- **Collision.** Bullet 0 overlaps tank 1's opaque pixels; bullet 1 overlaps only tank 1 (its own tank). Next frame start gives:
  - `hits_valid` pulse;
  - `tank_hit = 4'b0010`;
  - `bullet_hit = 4'b0001`.
- **Edges.** Tank at x = 1010: no wrap artefacts at x = 0..10. Tank with `dir = 4'b0110`: down sprite. Tank with `dir = 0`: 0xFFF fill.
- **Reset.** Assert `reset` at (320,240) mid-frame.
  - All outputs go to 0 immediately.
  - After release, the next `hits_valid` reports only post-reset overlaps.

Source files
------------

// File: rtl/sprite_layer_renderer_if.sv
// Pixel-side bundle for sprite_layer_renderer: scan coordinate, game-state sprite
// inputs, rendered colour and per-frame hit reports. The renderer takes the slave side.
interface sprite_layer_renderer_if #(
    parameter int NUM_TANKS = 4
);
    logic [9:0]              DrawX;
    logic [9:0]              DrawY;
    logic [10*NUM_TANKS-1:0] tank_x;
    logic [10*NUM_TANKS-1:0] tank_y;
    logic [4*NUM_TANKS-1:0]  tank_dir;
    logic [NUM_TANKS-1:0]    tank_show;
    logic [NUM_TANKS-1:0]    tank_enemy;
    logic [10*NUM_TANKS-1:0] bullet_x;
    logic [10*NUM_TANKS-1:0] bullet_y;
    logic [4*NUM_TANKS-1:0]  bullet_dir;
    logic [NUM_TANKS-1:0]    bullet_show;
    logic [3:0]              red;
    logic [3:0]              green;
    logic [3:0]              blue;
    logic                    pixel_opaque;
    logic [NUM_TANKS-1:0]    tank_hit;
    logic [NUM_TANKS-1:0]    bullet_hit;
    logic                    hits_valid;

    modport master (
        output DrawX, DrawY, tank_x, tank_y, tank_dir, tank_show, tank_enemy,
               bullet_x, bullet_y, bullet_dir, bullet_show,
        input  red, green, blue, pixel_opaque, tank_hit, bullet_hit, hits_valid
    );

    modport slave (
        input  DrawX, DrawY, tank_x, tank_y, tank_dir, tank_show, tank_enemy,
               bullet_x, bullet_y, bullet_dir, bullet_show,
        output red, green, blue, pixel_opaque, tank_hit, bullet_hit, hits_valid
    );
endinterface

// File: rtl/sprite_layer_renderer.sv
// Two-stage tank/bullet sprite renderer with bullet-on-tank hit detection.
// Optional macro SPRITE_COLLISION_EN builds the hit accumulators; otherwise hit outputs are 0.
module sprite_layer_renderer #(
    parameter int          NUM_TANKS   = 4,
    parameter int          TANK_SIZE   = 32,
    parameter int          BULLET_SIZE = 8,
    parameter logic [11:0] KEY_RGB     = 12'h000
) (
    input logic                    vga_clk,
    input logic                    reset,
    sprite_layer_renderer_if.slave bus
);
    localparam int TB = $clog2(TANK_SIZE);
    localparam int BB = $clog2(BULLET_SIZE);
    localparam int IW = (NUM_TANKS > 1) ? $clog2(NUM_TANKS) : 1;

    // 11-bit sums keep sprites near the right/bottom edge from wrapping to 0.
    function automatic logic covers(input logic [9:0] px, input logic [9:0] py,
                                    input logic [9:0] sx, input logic [9:0] sy,
                                    input logic [10:0] size);
        return (px >= sx) && ({1'b0, px} < ({1'b0, sx} + size)) &&
               (py >= sy) && ({1'b0, py} < ({1'b0, sy} + size));
    endfunction

    function automatic logic [1:0] dir_index(input logic [3:0] dir);
        logic [1:0] d;
        d = 2'd3;
        for (int k = 3; k >= 0; k--) begin
            if (dir[k]) d = 2'(k);
        end
        return d;
    endfunction

    // Tank art: oriented rows u / columns v; the two outer columns are keyed out.
    function automatic logic [11:0] tank_rom(input logic [3:0] dir, input logic [2*TB-1:0] addr);
        logic [TB-1:0] r, c, u, v;
        logic [1:0]    d;
        r = addr[2*TB-1:TB];
        c = addr[TB-1:0];
        d = dir_index(dir);
        case (d)
            2'd0:    begin u = r;  v = c; end
            2'd1:    begin u = ~r; v = c; end
            2'd2:    begin u = c;  v = r; end
            default: begin u = ~c; v = r; end
        endcase
        if (dir == 4'd0) return 12'hFFF;
        if (v[TB-1:1] == '0 || v[TB-1:1] == '1) return KEY_RGB;
        return {4'(u), 4'(v), 4'(d) + 4'd1};
    endfunction

    // Bullet art: the two trailing oriented rows are keyed out.
    function automatic logic [11:0] bullet_rom(input logic [3:0] dir, input logic [2*BB-1:0] addr);
        logic [BB-1:0] r, c, u;
        logic [1:0]    d;
        r = addr[2*BB-1:BB];
        c = addr[BB-1:0];
        d = dir_index(dir);
        case (d)
            2'd0:    u = r;
            2'd1:    u = ~r;
            2'd2:    u = c;
            default: u = ~c;
        endcase
        if (dir == 4'd0) return 12'hFFF;
        if (u[BB-1:1] == '0) return KEY_RGB;
        return {4'hF, 4'(u), 2'b10, d};
    endfunction

    logic [NUM_TANKS-1:0] tank_cover, bullet_cover;

    for (genvar i = 0; i < NUM_TANKS; i++) begin : g_cover
        assign tank_cover[i] = bus.tank_show[i] &&
            covers(bus.DrawX, bus.DrawY, bus.tank_x[10*i +: 10], bus.tank_y[10*i +: 10], 11'(TANK_SIZE));
        assign bullet_cover[i] = bus.bullet_show[i] &&
            covers(bus.DrawX, bus.DrawY, bus.bullet_x[10*i +: 10], bus.bullet_y[10*i +: 10], 11'(BULLET_SIZE));
    end

    logic          t_win_valid, b_win_valid;
    logic [IW-1:0] t_win_idx, b_win_idx;

    always_comb begin
        t_win_valid = 1'b0;
        t_win_idx   = '0;
        b_win_valid = 1'b0;
        b_win_idx   = '0;
        for (int i = NUM_TANKS - 1; i >= 0; i--) begin
            if (tank_cover[i]) begin
                t_win_valid = 1'b1;
                t_win_idx   = IW'(i);
            end
            if (bullet_cover[i]) begin
                b_win_valid = 1'b1;
                b_win_idx   = IW'(i);
            end
        end
    end

    logic [9:0]      t_x, t_y, b_x, b_y;
    logic [3:0]      t_dir, b_dir;
    logic [2*TB-1:0] t_addr;
    logic [2*BB-1:0] b_addr;

    assign t_x    = bus.tank_x[10*t_win_idx +: 10];
    assign t_y    = bus.tank_y[10*t_win_idx +: 10];
    assign t_dir  = bus.tank_dir[4*t_win_idx +: 4];
    assign b_x    = bus.bullet_x[10*b_win_idx +: 10];
    assign b_y    = bus.bullet_y[10*b_win_idx +: 10];
    assign b_dir  = bus.bullet_dir[4*b_win_idx +: 4];
    assign t_addr = {TB'(bus.DrawY - t_y), TB'(bus.DrawX - t_x)};
    assign b_addr = {BB'(bus.DrawY - b_y), BB'(bus.DrawX - b_x)};

    // Stage 0 register; the clocked ROM reads share this edge so colour is ready in stage 1.
    logic        s1_t_valid, s1_b_valid, s1_enemy;
    logic [11:0] s1_t_rom, s1_b_rom;

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            s1_t_valid <= 1'b0;
            s1_b_valid <= 1'b0;
            s1_enemy   <= 1'b0;
            s1_t_rom   <= '0;
            s1_b_rom   <= '0;
        end else begin
            s1_t_valid <= t_win_valid;
            s1_b_valid <= b_win_valid;
            s1_enemy   <= bus.tank_enemy[t_win_idx];
            s1_t_rom   <= tank_rom(t_dir, t_addr);
            s1_b_rom   <= bullet_rom(b_dir, b_addr);
        end
    end

    logic        t_opaque, b_opaque;
    logic [11:0] t_colour;

    assign t_opaque = s1_t_valid && (s1_t_rom != KEY_RGB);
    assign b_opaque = s1_b_valid && (s1_b_rom != KEY_RGB);
    // Enemy palette swaps the red and green nibbles.
    assign t_colour = s1_enemy ? {s1_t_rom[7:4], s1_t_rom[11:8], s1_t_rom[3:0]} : s1_t_rom;

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            bus.red          <= '0;
            bus.green        <= '0;
            bus.blue         <= '0;
            bus.pixel_opaque <= 1'b0;
        end else begin
            bus.pixel_opaque <= b_opaque || t_opaque;
            if (b_opaque) begin
                {bus.red, bus.green, bus.blue} <= s1_b_rom;
            end else if (t_opaque) begin
                {bus.red, bus.green, bus.blue} <= t_colour;
            end else begin
                {bus.red, bus.green, bus.blue} <= 12'h000;
            end
        end
    end

`ifdef SPRITE_COLLISION_EN
    logic [IW-1:0]        s1_t_idx, s1_b_idx;
    logic                 s1_frame_start, hit;
    logic [NUM_TANKS-1:0] tank_acc, bullet_acc, tank_new, bullet_new;

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            s1_t_idx       <= '0;
            s1_b_idx       <= '0;
            s1_frame_start <= 1'b0;
        end else begin
            s1_t_idx       <= t_win_idx;
            s1_b_idx       <= b_win_idx;
            s1_frame_start <= (bus.DrawX == 10'd0) && (bus.DrawY == 10'd0);
        end
    end

    assign hit        = t_opaque && b_opaque && (s1_t_idx != s1_b_idx);
    assign tank_new   = hit ? (NUM_TANKS'(1) << s1_t_idx) : '0;
    assign bullet_new = hit ? (NUM_TANKS'(1) << s1_b_idx) : '0;

    // The frame-start pixel itself belongs to the new frame.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            tank_acc       <= '0;
            bullet_acc     <= '0;
            bus.tank_hit   <= '0;
            bus.bullet_hit <= '0;
            bus.hits_valid <= 1'b0;
        end else if (s1_frame_start) begin
            bus.tank_hit   <= tank_acc;
            bus.bullet_hit <= bullet_acc;
            bus.hits_valid <= 1'b1;
            tank_acc       <= tank_new;
            bullet_acc     <= bullet_new;
        end else begin
            bus.hits_valid <= 1'b0;
            tank_acc       <= tank_acc | tank_new;
            bullet_acc     <= bullet_acc | bullet_new;
        end
    end
`else
    assign bus.tank_hit   = '0;
    assign bus.bullet_hit = '0;
    assign bus.hits_valid = 1'b0;
`endif
endmodule

// File: tb/tb_sprite_layer_renderer.sv
// Bench for sprite_layer_renderer: a pixel-level reference model predicts colour,
// opacity and frame hit reports; each scenario task compares two cycles later.
module tb_sprite_layer_renderer;
    localparam int N   = 4;
    localparam int TS  = 32;
    localparam int BS  = 8;
    localparam int KEY = 0;
    localparam int W   = 2 * N + 14;

    logic vga_clk = 1'b0;
    logic reset   = 1'b1;

    always #5 vga_clk = ~vga_clk;

    sprite_layer_renderer_if #(.NUM_TANKS(N)) bus ();

    sprite_layer_renderer #(
        .NUM_TANKS(N), .TANK_SIZE(TS), .BULLET_SIZE(BS), .KEY_RGB(12'h000)
    ) dut (
        .vga_clk(vga_clk),
        .reset(reset),
        .bus(bus)
    );

    int tx[N], ty[N], tdir[N], bx[N], by[N], bdir[N];
    bit tshow[N], tenemy[N], bshow[N];
    logic [N-1:0] acc_t, acc_b, rep_t, rep_b;
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    // Sprite art as defined for the ROMs, in oriented coordinates (u along travel).
    function automatic int sprite_colour(bit is_bullet, int dir, int r, int c);
        int s, d, u, v;
        s = is_bullet ? BS : TS;
        if (dir == 0) return 'hFFF;
        d = 0;
        while (((dir >> d) & 1) == 0) d++;
        case (d)
            0:       begin u = r;         v = c; end
            1:       begin u = s - 1 - r; v = c; end
            2:       begin u = c;         v = r; end
            default: begin u = s - 1 - c; v = r; end
        endcase
        if (is_bullet) return (u < 2) ? KEY : ('hF00 | ((u % 16) << 4) | (8 + d));
        return (v < 2 || v >= s - 2) ? KEY : (((u % 16) << 8) | ((v % 16) << 4) | (d + 1));
    endfunction

    task automatic model_pixel(input int x, input int y, output logic [W-1:0] e);
        int tw, bw, tc, bc;
        bit topq, bopq, hv;
        logic [11:0] rgb;
        tw = -1;
        bw = -1;
        for (int i = 0; i < N; i++) begin
            if (tw < 0 && tshow[i] && x >= tx[i] && x < tx[i] + TS && y >= ty[i] && y < ty[i] + TS) tw = i;
            if (bw < 0 && bshow[i] && x >= bx[i] && x < bx[i] + BS && y >= by[i] && y < by[i] + BS) bw = i;
        end
        tc = (tw >= 0) ? sprite_colour(1'b0, tdir[tw], y - ty[tw], x - tx[tw]) : KEY;
        bc = (bw >= 0) ? sprite_colour(1'b1, bdir[bw], y - by[bw], x - bx[bw]) : KEY;
        topq = (tw >= 0) && (tc != KEY);
        bopq = (bw >= 0) && (bc != KEY);
        if (bopq) rgb = 12'(bc);
        else if (topq && tenemy[tw]) rgb = 12'((((tc >> 4) & 15) << 8) | (((tc >> 8) & 15) << 4) | (tc & 15));
        else if (topq) rgb = 12'(tc);
        else rgb = 12'h000;
        hv = 1'b0;
`ifdef SPRITE_COLLISION_EN
        if (x == 0 && y == 0) begin
            rep_t = acc_t;
            rep_b = acc_b;
            acc_t = '0;
            acc_b = '0;
            hv = 1'b1;
        end
        if (bopq && topq && bw != tw) begin
            acc_t[tw] = 1'b1;
            acc_b[bw] = 1'b1;
        end
`endif
        e = {hv, rep_t, rep_b, bopq || topq, rgb};
    endtask

    task automatic drive_state();
        for (int i = 0; i < N; i++) begin
            bus.tank_x[10*i +: 10]   = 10'(tx[i]);
            bus.tank_y[10*i +: 10]   = 10'(ty[i]);
            bus.tank_dir[4*i +: 4]   = 4'(tdir[i]);
            bus.tank_show[i]         = tshow[i];
            bus.tank_enemy[i]        = tenemy[i];
            bus.bullet_x[10*i +: 10] = 10'(bx[i]);
            bus.bullet_y[10*i +: 10] = 10'(by[i]);
            bus.bullet_dir[4*i +: 4] = 4'(bdir[i]);
            bus.bullet_show[i]       = bshow[i];
        end
    endtask

    task automatic clear_sprites();
        for (int i = 0; i < N; i++) begin
            tx[i] = 0; ty[i] = 0; tdir[i] = 1; tshow[i] = 0; tenemy[i] = 0;
            bx[i] = 0; by[i] = 0; bdir[i] = 1; bshow[i] = 0;
        end
    endtask

    // One pixel per clock: sample outputs just after the edge (they belong to the
    // pixel driven two calls earlier), then present the next pixel.
    task automatic clk_pixel(input int x, input int y, output logic [W-1:0] obs,
                             output logic [W-1:0] expv, output bit have);
        logic [W-1:0] e;
        @(posedge vga_clk);
        #1;
        obs = {bus.hits_valid, bus.tank_hit, bus.bullet_hit, bus.pixel_opaque, bus.red, bus.green, bus.blue};
        have = 1'b0;
        expv = '0;
        if (exp_q.size() >= 2) begin
            expv = exp_q.pop_front();
            have = 1'b1;
        end
        bus.DrawX = 10'(x);
        bus.DrawY = 10'(y);
        drive_state();
        model_pixel(x, y, e);
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        logic [W-1:0] obs;
        obs = {bus.hits_valid, bus.tank_hit, bus.bullet_hit, bus.pixel_opaque, bus.red, bus.green, bus.blue};
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_values: got %h expected %h", obs, {W{1'b0}});
        end
        reset = 1'b0;
    endtask

    task automatic test_single_tank();
        logic [W-1:0] obs, expv;
        bit have;
        clear_sprites();
        tx[0] = 100; ty[0] = 100; tdir[0] = 1; tshow[0] = 1;
        for (int y = 100; y < 132; y++) begin
            for (int x = 100; x <= 132; x++) begin
                clk_pixel(x, y, obs, expv, have);
                if (have) begin
                    checks++;
                    if (obs !== expv) begin
                        errors++;
                        $display("FAIL single_tank: got %h expected %h", obs, expv);
                    end
                end
            end
        end
    endtask

    task automatic test_priority();
        logic [W-1:0] obs, expv;
        bit have;
        clear_sprites();
        tx[1] = 200; ty[1] = 50; tdir[1] = 1; tshow[1] = 1;
        tx[2] = 200; ty[2] = 50; tdir[2] = 8; tshow[2] = 1; tenemy[2] = 1;
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) tshow[1] = 0;
            for (int n = 0; n < 80; n++) begin
                clk_pixel($urandom_range(195, 235), $urandom_range(45, 85), obs, expv, have);
                if (have) begin
                    checks++;
                    if (obs !== expv) begin
                        errors++;
                        $display("FAIL priority pass %0d: got %h expected %h", pass, obs, expv);
                    end
                end
            end
        end
    endtask

    task automatic test_transparency();
        logic [W-1:0] obs, expv;
        bit have;
        clear_sprites();
        tx[1] = 100; ty[1] = 100; tdir[1] = 4; tshow[1] = 1;
        bx[0] = 104; by[0] = 104; bdir[0] = 2; bshow[0] = 1;
        for (int y = 102; y < 114; y++) begin
            for (int x = 102; x < 114; x++) begin
                clk_pixel(x, y, obs, expv, have);
                if (have) begin
                    checks++;
                    if (obs !== expv) begin
                        errors++;
                        $display("FAIL transparency: got %h expected %h", obs, expv);
                    end
                end
            end
        end
    endtask

    task automatic test_edges();
        logic [W-1:0] obs, expv;
        bit have;
        int dirs[3] = '{6, 0, 8};
        clear_sprites();
        tx[0] = 1010; ty[0] = 0; tdir[0] = 1; tshow[0] = 1;
        for (int y = 0; y < 4; y++) begin
            for (int x = 1; x < 35; x++) begin
                clk_pixel((x <= 10) ? x : 1023 - (x - 11), y, obs, expv, have);
                if (have) begin
                    checks++;
                    if (obs !== expv) begin
                        errors++;
                        $display("FAIL edge_wrap: got %h expected %h", obs, expv);
                    end
                end
            end
        end
        tx[0] = 400; ty[0] = 400;
        for (int k = 0; k < 3; k++) begin
            tdir[0] = dirs[k];
            for (int n = 0; n < 30; n++) begin
                clk_pixel($urandom_range(400, 431), $urandom_range(400, 431), obs, expv, have);
                if (have) begin
                    checks++;
                    if (obs !== expv) begin
                        errors++;
                        $display("FAIL edge_dir %0d: got %h expected %h", dirs[k], obs, expv);
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] obs, expv;
        bit have;
        int x, y, k;
        for (int n = 0; n < 800; n++) begin
            if (n % 100 == 0) begin
                for (int i = 0; i < N; i++) begin
                    tx[i] = $urandom_range(60, 180); ty[i] = $urandom_range(60, 180);
                    tdir[i] = $urandom_range(0, 15); tshow[i] = ($urandom_range(0, 3) != 0);
                    tenemy[i] = $urandom_range(0, 1);
                    bx[i] = $urandom_range(60, 210); by[i] = $urandom_range(60, 210);
                    bdir[i] = $urandom_range(0, 15); bshow[i] = ($urandom_range(0, 3) != 0);
                end
            end
            if ($urandom_range(0, 19) == 0) begin
                k = $urandom_range(0, N - 1);
                bx[k] = $urandom_range(60, 210);
            end
            if ($urandom_range(0, 49) == 0) begin
                x = 0; y = 0;
            end else begin
                x = $urandom_range(50, 230); y = $urandom_range(50, 230);
            end
            clk_pixel(x, y, obs, expv, have);
            if (have) begin
                checks++;
                if (obs !== expv) begin
                    errors++;
                    $display("FAIL random: got %h expected %h", obs, expv);
                end
            end
        end
    endtask

    task automatic test_collision();
        logic [W-1:0] obs, expv;
        logic [2*N:0] want;
        bit have;
        clear_sprites();
        tx[1] = 100; ty[1] = 100; tdir[1] = 1; tshow[1] = 1;
        bx[0] = 104; by[0] = 104; bdir[0] = 8; bshow[0] = 1;
        bx[1] = 116; by[1] = 116; bdir[1] = 1; bshow[1] = 1;
        for (int n = -1; n < 32 * 32 + 3; n++) begin
            if (n < 0) clk_pixel(0, 0, obs, expv, have);
            else if (n < 32 * 32) clk_pixel(100 + n % 32, 100 + n / 32, obs, expv, have);
            else if (n == 32 * 32) clk_pixel(0, 0, obs, expv, have);
            else clk_pixel(600, 400, obs, expv, have);
            if (have) begin
                checks++;
                if (obs !== expv) begin
                    errors++;
                    $display("FAIL collision: got %h expected %h", obs, expv);
                end
            end
        end
`ifdef SPRITE_COLLISION_EN
        want = {1'b1, 4'b0010, 4'b0001};
`else
        want = '0;
`endif
        checks++;
        if (obs[W-1 -: 2*N+1] !== want) begin
            errors++;
            $display("FAIL collision_report: got %h expected %h", obs[W-1 -: 2*N+1], want);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] obs, expv;
        logic [2*N:0] want;
        bit have;
        clear_sprites();
        tx[1] = 100; ty[1] = 100; tdir[1] = 1; tshow[1] = 1;
        tx[2] = 310; ty[2] = 230; tdir[2] = 2; tshow[2] = 1; tenemy[2] = 1;
        bx[0] = 104; by[0] = 104; bdir[0] = 1; bshow[0] = 1;
        for (int n = 0; n < 67; n++) begin
            if (n < 64) clk_pixel(104 + n % 8, 104 + n / 8, obs, expv, have);
            else clk_pixel(320, 240, obs, expv, have);
            if (have) begin
                checks++;
                if (obs !== expv) begin
                    errors++;
                    $display("FAIL reset_mid_pre: got %h expected %h", obs, expv);
                end
            end
        end
        #2 reset = 1'b1;
        #1;
        obs = {bus.hits_valid, bus.tank_hit, bus.bullet_hit, bus.pixel_opaque, bus.red, bus.green, bus.blue};
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_mid_async: got %h expected %h", obs, {W{1'b0}});
        end
        exp_q.delete();
        acc_t = '0; acc_b = '0; rep_t = '0; rep_b = '0;
        repeat (2) @(posedge vga_clk);
        #1 reset = 1'b0;
        bshow[0] = 0;
        bx[2] = 120; by[2] = 104; bdir[2] = 1; bshow[2] = 1;
        for (int n = 0; n < 67; n++) begin
            if (n < 64) clk_pixel(120 + n % 8, 104 + n / 8, obs, expv, have);
            else if (n == 64) clk_pixel(0, 0, obs, expv, have);
            else clk_pixel(600, 400, obs, expv, have);
            if (have) begin
                checks++;
                if (obs !== expv) begin
                    errors++;
                    $display("FAIL reset_mid_post: got %h expected %h", obs, expv);
                end
            end
        end
`ifdef SPRITE_COLLISION_EN
        want = {1'b1, 4'b0010, 4'b0100};
`else
        want = '0;
`endif
        checks++;
        if (obs[W-1 -: 2*N+1] !== want) begin
            errors++;
            $display("FAIL reset_mid_report: got %h expected %h", obs[W-1 -: 2*N+1], want);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] obs, expv;
        bit have;
        clear_sprites();
        tx[3] = 500; ty[3] = 300; tdir[3] = 2; tshow[3] = 1;
        bx[3] = 510; by[3] = 310; bdir[3] = 4; bshow[3] = 1;
        for (int n = 0; n < 64; n++) begin
            tx[3] = 500 + (n % 3);
            clk_pixel(505 + n % 16, 305 + n / 16 * 3, obs, expv, have);
            if (have) begin
                checks++;
                if (obs !== expv) begin
                    errors++;
                    $display("FAIL back_to_back: got %h expected %h", obs, expv);
                end
            end
        end
        for (int n = 0; n < 2; n++) begin
            clk_pixel(700, 500, obs, expv, have);
            if (have) begin
                checks++;
                if (obs !== expv) begin
                    errors++;
                    $display("FAIL back_to_back_flush: got %h expected %h", obs, expv);
                end
            end
        end
    endtask

    initial begin
        clear_sprites();
        acc_t = '0; acc_b = '0; rep_t = '0; rep_b = '0;
        bus.DrawX = 10'd700;
        bus.DrawY = 10'd500;
        drive_state();
        repeat (3) @(posedge vga_clk);
        #1;
        test_reset();
        test_single_tank();
        test_priority();
        test_transparency();
        test_edges();
        test_random();
        test_collision();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
